// File: rtl/pe_out_drain.sv
// pe_out_drain: buffers PE result pairs in a DEPTH-entry FIFO and serializes each pair as two words.
// Define PE_DRAIN_NAN_FLAG_EN to add the sticky io_nan_seen output.
module pe_out_drain #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_0,
  input  logic [31:0] io_in_1,
  input  logic        io_in_last,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_bits,
  output logic        io_out_last,
  output logic [7:0]  io_count,
`ifdef PE_DRAIN_NAN_FLAG_EN
  output logic        io_nan_seen,
`endif
  output logic        io_busy
);

  localparam int DATA_W = 32;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_OCC  = (AW+1)'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND0 = 2'd1;
  localparam logic [1:0] SEND1 = 2'd2;

  logic [DATA_W-1:0] mem_0 [DEPTH];
  logic [DATA_W-1:0] mem_1 [DEPTH];
  logic              mem_last [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    count;
  logic          push;
  logic          pop;
  logic          out_hs;

  assign io_in_ready  = (occ != FULL_OCC);
  assign push         = io_in_valid && io_in_ready;
  assign io_out_valid = (state == SEND0) || (state == SEND1);
  assign out_hs       = io_out_valid && io_out_ready;
  assign pop          = (state == SEND1) && io_out_ready;
  assign io_busy      = (occ != '0);
  assign io_count     = count;

  // FIFO storage is data only and carries no reset; occupancy guards every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_0[wr_ptr]    <= io_in_0;
      mem_1[wr_ptr]    <= io_in_1;
      mem_last[wr_ptr] <= io_in_last;
    end
  end

  // A push landing on the SEND1 pop edge counts as "another entry remains", so no bubble appears.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (occ != '0) state_nxt = SEND0;
      SEND0:   if (io_out_ready) state_nxt = SEND1;
      SEND1:   if (io_out_ready) state_nxt = ((occ > ONE_OCC) || push) ? SEND0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io_out_bits = '0;
    io_out_last = 1'b0;
    case (state)
      SEND0: io_out_bits = mem_0[rd_ptr];
      SEND1: begin
        io_out_bits = mem_1[rd_ptr];
        io_out_last = mem_last[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      state  <= IDLE;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PE_DRAIN_NAN_FLAG_EN
  function automatic logic is_nan(input logic [DATA_W-1:0] w);
    return (&w[30:23]) && (|w[22:0]);
  endfunction

  logic nan_seen;
  assign io_nan_seen = nan_seen;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nan_seen <= 1'b0;
    end else if (out_hs && is_nan(io_out_bits)) begin
      nan_seen <= 1'b1;
    end
  end
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
`endif

endmodule

// File: tb/tb_pe_out_drain.sv
// Directed bench for pe_out_drain: reset, single pair, backpressure, stall hold, count wrap, async reset, NaN flag.
module tb_pe_out_drain;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_0 = '0;
  logic [31:0] io_in_1 = '0;
  logic        io_in_last = 1'b0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_bits;
  logic        io_out_last;
  logic [7:0]  io_count;
  logic        io_busy;
`ifdef PE_DRAIN_NAN_FLAG_EN
  logic        io_nan_seen;
`endif

  pe_out_drain #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_0     (io_in_0),
    .io_in_1     (io_in_1),
    .io_in_last  (io_in_last),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits (io_out_bits),
    .io_out_last (io_out_last),
    .io_count    (io_count),
`ifdef PE_DRAIN_NAN_FLAG_EN
    .io_nan_seen (io_nan_seen),
`endif
    .io_busy     (io_busy)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          words_out = 0;
  logic [32:0] exp_q [$];
  bit          acc_flag = 1'b0;
  bit          toggle_mode = 1'b0;
  bit          stall_prev = 1'b0;
  logic [32:0] stall_word = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock with scoreboarding of both handshakes and of stall stability.
  task automatic cycle();
    bit in_hs;
    bit out_hs;
    in_hs  = io_in_valid && io_in_ready;
    out_hs = io_out_valid && io_out_ready;
    if (stall_prev) begin
      chk("hold_valid", 64'(io_out_valid), 64'd1);
      chk("hold_word", 64'({io_out_last, io_out_bits}), 64'(stall_word));
    end
    stall_prev = io_out_valid && !io_out_ready;
    stall_word = {io_out_last, io_out_bits};
    if (out_hs) begin
      words_out++;
      chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("word", 64'({io_out_last, io_out_bits}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (in_hs) begin
      exp_q.push_back({1'b0, io_in_0});
      exp_q.push_back({io_in_last, io_in_1});
    end
    acc_flag = in_hs;
    tick();
    if (in_hs) io_in_valid = 1'b0;
    if (toggle_mode) io_out_ready = ~io_out_ready;
  endtask

  task automatic send_pair(input logic [31:0] d0, input logic [31:0] d1, input logic lst);
    int n;
    io_in_0 = d0;
    io_in_1 = d1;
    io_in_last = lst;
    io_in_valid = 1'b1;
    n = 0;
    acc_flag = 1'b0;
    while (!acc_flag && n < 50) begin
      cycle();
      n++;
    end
    if (!acc_flag) chk("send_accept_timeout", 64'(acc_flag), 64'd1);
  endtask

  task automatic drain(input int max_cyc, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < max_cyc) begin
      cycle();
      used++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int used;
    int w0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 64'(io_in_ready), 64'd1);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_out_last", 64'(io_out_last), 64'd0);
    chk("rst_out_bits", 64'(io_out_bits), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_count", 64'(io_count), 64'd0);
`ifdef PE_DRAIN_NAN_FLAG_EN
    chk("rst_nan", 64'(io_nan_seen), 64'd0);
`endif
    reset = 1'b1;
    tick();

    // Single pair with minimum latency
    io_out_ready = 1'b1;
    io_in_0 = 32'h3F80_0000;
    io_in_1 = 32'h4000_0000;
    io_in_last = 1'b1;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    chk("single_not_yet_valid", 64'(io_out_valid), 64'd0);
    tick();
    chk("single_w0_valid", 64'(io_out_valid), 64'd1);
    chk("single_w0_bits", 64'(io_out_bits), 64'h3F80_0000);
    chk("single_w0_last", 64'(io_out_last), 64'd0);
    tick();
    chk("single_w1_bits", 64'(io_out_bits), 64'h4000_0000);
    chk("single_w1_last", 64'(io_out_last), 64'd1);
    tick();
    chk("single_done_valid", 64'(io_out_valid), 64'd0);
    chk("single_done_busy", 64'(io_busy), 64'd0);
    chk("single_count", 64'(io_count), 64'd1);

    // Backpressure: fill all four entries, fifth pair refused
    io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready_before_push", 64'(io_in_ready), 64'd1);
      send_pair(32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i), i[0]);
    end
    chk("bp_ready_full", 64'(io_in_ready), 64'd0);
    io_in_0 = 32'hB000_0004;
    io_in_1 = 32'hC000_0004;
    io_in_last = 1'b1;
    io_in_valid = 1'b1;
    cycle();
    cycle();
    chk("bp_held_count", 64'(io_count), 64'd5);
    chk("bp_held_ready", 64'(io_in_ready), 64'd0);
    io_out_ready = 1'b1;
    w0 = words_out;
    drain(30, used);
    chk("bp_words", 64'(words_out - w0), 64'd10);
    chk("bp_no_bubble_cycles", 64'(used), 64'd10);
    chk("bp_count", 64'(io_count), 64'd6);
    chk("bp_busy", 64'(io_busy), 64'd0);

    // Stall stability with out_ready toggling each cycle
    toggle_mode = 1'b1;
    io_out_ready = 1'b0;
    w0 = words_out;
    send_pair(32'h0A0A_0001, 32'h0B0B_0001, 1'b0);
    send_pair(32'h0A0A_0002, 32'h0B0B_0002, 1'b0);
    send_pair(32'h0A0A_0003, 32'h0B0B_0003, 1'b1);
    drain(40, used);
    toggle_mode = 1'b0;
    io_out_ready = 1'b1;
    stall_prev = 1'b0;
    chk("stall_words", 64'(words_out - w0), 64'd6);
    chk("stall_count", 64'(io_count), 64'd9);
    chk("stall_busy", 64'(io_busy), 64'd0);

    // Reset during SEND1 of the second of three pairs
    io_in_0 = 32'h11; io_in_1 = 32'h12; io_in_last = 1'b0; io_in_valid = 1'b1;
    tick();
    io_in_0 = 32'h21; io_in_1 = 32'h22; io_in_last = 1'b1;
    tick();
    chk("mid_a0", 64'(io_out_bits), 64'h11);
    io_in_0 = 32'h31; io_in_1 = 32'h32; io_in_last = 1'b1;
    tick();
    io_in_valid = 1'b0;
    chk("mid_a1", 64'(io_out_bits), 64'h12);
    tick();
    chk("mid_b0", 64'(io_out_bits), 64'h21);
    tick();
    chk("mid_b1", 64'(io_out_bits), 64'h22);
    chk("mid_b1_last", 64'(io_out_last), 64'd1);
    chk("mid_count", 64'(io_count), 64'd12);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(io_out_valid), 64'd0);
    chk("arst_out_bits", 64'(io_out_bits), 64'd0);
    chk("arst_out_last", 64'(io_out_last), 64'd0);
    chk("arst_busy", 64'(io_busy), 64'd0);
    chk("arst_in_ready", 64'(io_in_ready), 64'd1);
    chk("arst_count", 64'(io_count), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_valid", 64'(io_out_valid), 64'd0);
    chk("post_rst_busy", 64'(io_busy), 64'd0);
    chk("post_rst_ready", 64'(io_in_ready), 64'd1);
    chk("post_rst_count", 64'(io_count), 64'd0);

    // Count and pointer wrap over 257 pairs
    exp_q.delete();
    w0 = words_out;
    for (int i = 0; i < 257; i++) begin
      send_pair(32'h0001_0000 | 32'(i), 32'h0002_0000 | 32'(i), (i % 16) == 15);
    end
    drain(20, used);
    chk("wrap_count", 64'(io_count), 64'd1);
    chk("wrap_words", 64'(words_out - w0), 64'd514);
    chk("wrap_busy", 64'(io_busy), 64'd0);

`ifdef PE_DRAIN_NAN_FLAG_EN
    // Infinity alone leaves the flag clear; a quiet NaN sets it for good
    send_pair(32'h7F80_0000, 32'h0000_0000, 1'b1);
    drain(20, used);
    chk("nan_inf_clear", 64'(io_nan_seen), 64'd0);
    send_pair(32'h7FC0_0000, 32'h3F80_0000, 1'b0);
    drain(20, used);
    chk("nan_set", 64'(io_nan_seen), 64'd1);
    send_pair(32'h0000_0001, 32'h0000_0002, 1'b1);
    drain(20, used);
    chk("nan_sticky", 64'(io_nan_seen), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
